// File: rtl/mcu_link_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : mcu_link_pkg                                                    |
// | Purpose  : Shared opcodes, frame lengths, power-on codes, FSM state types  |
// |            and byte builders for the FPGA<->MCU UART link responder.       |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
package mcu_link_pkg;

   // Opcode nibbles carried in byte[7:4] of the first byte of every frame
   localparam logic [3:0] OP_ACK     = 4'h1;
   localparam logic [3:0] OP_STAGE   = 4'h2;
   localparam logic [3:0] OP_VERSION = 4'h3;
   localparam logic [3:0] OP_IP      = 4'h4;
   localparam logic [3:0] OP_STATUS  = 4'h5;
   localparam logic [3:0] OP_POWERON = 4'h6;

   // Total frame lengths in bytes, opcode byte included
   localparam int IP_LEN  = 17;
   localparam int VER_LEN = 9;

   // Low two bits of a power-on report byte
   localparam logic [1:0] PWR_ON  = 2'b01;
   localparam logic [1:0] PWR_OFF = 2'b10;

   typedef enum logic [1:0] {
      RX_IDLE = 2'd0,
      RX_VER  = 2'd1,
      RX_IP   = 2'd2
   } rx_state_t;

   typedef enum logic {
      TX_IDLE = 1'b0,
      TX_WAIT = 1'b1
   } tx_state_t;

   function automatic logic [7:0] status_byte(input logic [1:0] s, input logic pa, input logic aa);
      return {OP_STATUS, s, pa, aa};
   endfunction

   function automatic logic [7:0] poweron_byte(input logic on);
      return {OP_POWERON, 2'b00, (on ? PWR_ON : PWR_OFF)};
   endfunction

endpackage
`default_nettype wire

// File: rtl/mcu_link_tx_sched.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : mcu_link_tx_sched                                               |
// | Purpose  : Pending-flag set, fixed-priority byte selection and one-byte-   |
// |            at-a-time handshake with the external UART transmitter.         |
// |            MCU_LINK_ACK_EN adds a lowest-priority ACK (0x10) flag.         |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module mcu_link_tx_sched
   import mcu_link_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   input  logic       req_status,
   input  logic       req_push,
   input  logic       req_poweron,
   input  logic       req_ack,
   input  logic [1:0] slot,
   input  logic       power_amplifier,
   input  logic       audio_amplifier,
   input  logic       poweron,
   input  logic       tx_active,
   input  logic       tx_done,
   output logic       tx_dv,
   output logic [7:0] tx_byte
);

   tx_state_t r_state;
   logic      r_pend_status;
   logic      r_pend_push;
   logic      r_pend_poweron;
`ifdef MCU_LINK_ACK_EN
   logic      r_pend_ack;
`else
   logic      w_unused_ack;
   assign w_unused_ack = req_ack;
`endif

   // Latch requests, launch the highest-priority pending byte, wait for tx_done.
   // A flag cleared at launch is re-armed if a fresh request lands that same cycle.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state        <= TX_IDLE;
         r_pend_status  <= 1'b0;
         r_pend_push    <= 1'b0;
         r_pend_poweron <= 1'b0;
`ifdef MCU_LINK_ACK_EN
         r_pend_ack     <= 1'b0;
`endif
         tx_dv          <= 1'b0;
         tx_byte        <= 8'h00;
      end else begin
         tx_dv <= 1'b0;
         if (req_status)  r_pend_status  <= 1'b1;
         if (req_push)    r_pend_push    <= 1'b1;
         if (req_poweron) r_pend_poweron <= 1'b1;
`ifdef MCU_LINK_ACK_EN
         if (req_ack)     r_pend_ack     <= 1'b1;
`endif
         case (r_state)
            TX_IDLE: begin
               if (!tx_active) begin
                  if (r_pend_status || r_pend_push) begin
                     tx_byte       <= status_byte(slot, power_amplifier, audio_amplifier);
                     tx_dv         <= 1'b1;
                     r_pend_status <= req_status;
                     r_pend_push   <= req_push;
                     r_state       <= TX_WAIT;
                  end else if (r_pend_poweron) begin
                     tx_byte        <= poweron_byte(poweron);
                     tx_dv          <= 1'b1;
                     r_pend_poweron <= req_poweron;
                     r_state        <= TX_WAIT;
                  end
`ifdef MCU_LINK_ACK_EN
                  else if (r_pend_ack) begin
                     tx_byte    <= {OP_ACK, 4'h0};
                     tx_dv      <= 1'b1;
                     r_pend_ack <= req_ack;
                     r_state    <= TX_WAIT;
                  end
`endif
               end
            end
            TX_WAIT: begin
               if (tx_done) r_state <= TX_IDLE;
            end
            default: r_state <= TX_IDLE;
         endcase
      end
   end

endmodule
`default_nettype wire

// File: rtl/mcu_link_responder.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : mcu_link_responder                                              |
// | Purpose  : MCU-side endpoint of the FPGA<->MCU UART link. Parses inbound   |
// |            frames into registers, answers requests and pushes local key    |
// |            status changes. Optional macro MCU_LINK_ACK_EN enables ACKs.    |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module mcu_link_responder
   import mcu_link_pkg::*;
#(
   parameter int         TIMEOUT_CYCLES = 1228800,
   parameter logic [1:0] RST_SLOT       = 2'd0,
   parameter logic       RST_POWERON    = 1'b0
)(
   input  logic        clk,
   input  logic        rst,
   input  logic        rx_dv,
   input  logic [7:0]  rx_byte,
   output logic        tx_dv,
   output logic [7:0]  tx_byte,
   input  logic        tx_active,
   input  logic        tx_done,
   input  logic        local_set,
   input  logic [1:0]  local_slot,
   input  logic        local_pa,
   input  logic        local_aa,
   output logic [31:0] ip,
   output logic        ip_valid,
   output logic [63:0] fw_version,
   output logic [3:0]  fw_type,
   output logic        version_valid,
   output logic [3:0]  stage,
   output logic        stage_stb,
   output logic [1:0]  slot,
   output logic        power_amplifier,
   output logic        audio_amplifier,
   output logic        status_stb,
   output logic        poweron,
   output logic        poweron_stb,
   output logic        frame_error
);

   localparam int              TW           = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [TW-1:0]   C_TIMER_LAST = TW'(TIMEOUT_CYCLES - 1);
   localparam logic [3:0]      C_IP_LAST    = 4'(IP_LEN - 2);
   localparam logic [3:0]      C_VER_LAST   = 4'(VER_LEN - 2);

   rx_state_t     r_rx_state;
   logic [3:0]    r_cnt;
   logic [TW-1:0] r_timer;
   logic [31:0]   r_ip_shadow;
   logic [63:0]   r_ver_shadow;
   logic          r_pad_bad;
   logic          r_req_status;
   logic          r_req_poweron;
   logic          r_req_push;
   logic          r_req_ack;

   logic [3:0]    w_op;
   logic [3:0]    w_arg;
   assign w_op  = rx_byte[7:4];
   assign w_arg = rx_byte[3:0];

   // Inbound frame parser; local key updates are applied last so they win a tie.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_rx_state      <= RX_IDLE;
         r_cnt           <= 4'd0;
         r_timer         <= '0;
         r_ip_shadow     <= 32'h0;
         r_ver_shadow    <= 64'h0;
         r_pad_bad       <= 1'b0;
         r_req_status    <= 1'b0;
         r_req_poweron   <= 1'b0;
         r_req_push      <= 1'b0;
         r_req_ack       <= 1'b0;
         ip              <= 32'h0;
         ip_valid        <= 1'b0;
         fw_version      <= 64'h0;
         fw_type         <= 4'h0;
         version_valid   <= 1'b0;
         stage           <= 4'h0;
         stage_stb       <= 1'b0;
         slot            <= RST_SLOT;
         power_amplifier <= 1'b0;
         audio_amplifier <= 1'b0;
         status_stb      <= 1'b0;
         poweron         <= RST_POWERON;
         poweron_stb     <= 1'b0;
         frame_error     <= 1'b0;
      end else begin
         stage_stb     <= 1'b0;
         status_stb    <= 1'b0;
         poweron_stb   <= 1'b0;
         frame_error   <= 1'b0;
         r_req_status  <= 1'b0;
         r_req_poweron <= 1'b0;
         r_req_push    <= 1'b0;
         r_req_ack     <= 1'b0;
         case (r_rx_state)
            RX_IDLE: begin
               r_timer <= '0;
               r_cnt   <= 4'd0;
               if (rx_dv) begin
                  case (w_op)
                     OP_STAGE: begin
                        stage     <= w_arg;
                        stage_stb <= 1'b1;
                        r_req_ack <= 1'b1;
                     end
                     OP_VERSION: begin
                        fw_type    <= w_arg;
                        r_rx_state <= RX_VER;
                     end
                     OP_IP: begin
                        if (w_arg == 4'h0) begin
                           r_pad_bad  <= 1'b0;
                           r_rx_state <= RX_IP;
                        end else begin
                           frame_error <= 1'b1;
                        end
                     end
                     OP_STATUS: begin
                        if (w_arg == 4'h0) begin
                           r_req_status <= 1'b1;
                        end else begin
                           slot            <= w_arg[3:2];
                           power_amplifier <= w_arg[1];
                           audio_amplifier <= w_arg[0];
                           status_stb      <= 1'b1;
                           r_req_ack       <= 1'b1;
                        end
                     end
                     OP_POWERON: begin
                        case (w_arg)
                           4'h0: r_req_poweron <= 1'b1;
                           4'h1: begin
                              poweron     <= 1'b1;
                              poweron_stb <= 1'b1;
                              r_req_ack   <= 1'b1;
                           end
                           4'h2: begin
                              poweron     <= 1'b0;
                              poweron_stb <= 1'b1;
                              r_req_ack   <= 1'b1;
                           end
                           default: frame_error <= 1'b1;
                        endcase
                     end
                     default: frame_error <= 1'b1;
                  endcase
               end
            end
            RX_VER, RX_IP: begin
               if (rx_dv) begin
                  r_timer <= '0;
                  r_cnt   <= r_cnt + 4'd1;
                  if (r_rx_state == RX_VER) begin
                     r_ver_shadow <= {r_ver_shadow[55:0], rx_byte};
                     if (r_cnt == C_VER_LAST) begin
                        fw_version    <= {r_ver_shadow[55:0], rx_byte};
                        version_valid <= 1'b1;
                        r_req_ack     <= 1'b1;
                        r_rx_state    <= RX_IDLE;
                     end
                  end else begin
                     if (r_cnt < 4'd4) r_ip_shadow <= {r_ip_shadow[23:0], rx_byte};
                     if (r_cnt == C_IP_LAST) begin
                        r_rx_state <= RX_IDLE;
                        if (r_pad_bad || (rx_byte != 8'h00)) begin
                           frame_error <= 1'b1;
                        end else begin
                           ip        <= r_ip_shadow;
                           ip_valid  <= 1'b1;
                           r_req_ack <= 1'b1;
                        end
                     end else if ((r_cnt >= 4'd4) && (rx_byte != 8'h00)) begin
                        r_pad_bad <= 1'b1;
                     end
                  end
               end else if (r_timer == C_TIMER_LAST) begin
                  frame_error <= 1'b1;
                  r_rx_state  <= RX_IDLE;
               end else begin
                  r_timer <= r_timer + 1'b1;
               end
            end
            default: r_rx_state <= RX_IDLE;
         endcase
         if (local_set) begin
            slot            <= local_slot;
            power_amplifier <= local_pa;
            audio_amplifier <= local_aa;
            status_stb      <= 1'b1;
            r_req_push      <= 1'b1;
         end
      end
   end

   mcu_link_tx_sched u_tx_sched (
      .clk             (clk),
      .rst             (rst),
      .req_status      (r_req_status),
      .req_push        (r_req_push),
      .req_poweron     (r_req_poweron),
      .req_ack         (r_req_ack),
      .slot            (slot),
      .power_amplifier (power_amplifier),
      .audio_amplifier (audio_amplifier),
      .poweron         (poweron),
      .tx_active       (tx_active),
      .tx_done         (tx_done),
      .tx_dv           (tx_dv),
      .tx_byte         (tx_byte)
   );

endmodule
`default_nettype wire

// File: tb/tb_mcu_link_responder.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_mcu_link_responder                                           |
// | Purpose  : Self-checking bench for mcu_link_responder with a simple UART   |
// |            TX model and a queue of expected transmitted bytes.             |
// |            Honours MCU_LINK_ACK_EN when expecting ACK bytes.               |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module tb_mcu_link_responder;

   localparam int TIMEOUT = 64;

   logic        clk = 1'b0;
   logic        rst;
   logic        rx_dv;
   logic [7:0]  rx_byte;
   logic        tx_dv;
   logic [7:0]  tx_byte;
   logic        tx_active;
   logic        tx_done;
   logic        local_set;
   logic [1:0]  local_slot;
   logic        local_pa;
   logic        local_aa;
   logic [31:0] ip;
   logic        ip_valid;
   logic [63:0] fw_version;
   logic [3:0]  fw_type;
   logic        version_valid;
   logic [3:0]  stage;
   logic        stage_stb;
   logic [1:0]  slot;
   logic        power_amplifier;
   logic        audio_amplifier;
   logic        status_stb;
   logic        poweron;
   logic        poweron_stb;
   logic        frame_error;

   int          n_cmp = 0;
   int          n_bad = 0;
   logic [7:0]  exp_q[$];
   logic [7:0]  act_mem [0:255];
   int          act_wr = 0;
   int          act_rd = 0;
   int          n_err = 0;
   int          n_stage_stb = 0;
   int          n_status_stb = 0;
   int          n_pon_stb = 0;
   logic        hold_busy;
   logic        model_busy;
   int          model_cnt;

   always #5 clk = ~clk;

   mcu_link_responder #(
      .TIMEOUT_CYCLES (TIMEOUT),
      .RST_SLOT       (2'd0),
      .RST_POWERON    (1'b0)
   ) dut (
      .clk             (clk),
      .rst             (rst),
      .rx_dv           (rx_dv),
      .rx_byte         (rx_byte),
      .tx_dv           (tx_dv),
      .tx_byte         (tx_byte),
      .tx_active       (tx_active),
      .tx_done         (tx_done),
      .local_set       (local_set),
      .local_slot      (local_slot),
      .local_pa        (local_pa),
      .local_aa        (local_aa),
      .ip              (ip),
      .ip_valid        (ip_valid),
      .fw_version      (fw_version),
      .fw_type         (fw_type),
      .version_valid   (version_valid),
      .stage           (stage),
      .stage_stb       (stage_stb),
      .slot            (slot),
      .power_amplifier (power_amplifier),
      .audio_amplifier (audio_amplifier),
      .status_stb      (status_stb),
      .poweron         (poweron),
      .poweron_stb     (poweron_stb),
      .frame_error     (frame_error)
   );

   assign tx_active = model_busy | hold_busy;

   // UART transmitter stand-in: busy for a few cycles after each tx_dv, then tx_done
   always @(posedge clk) begin
      if (rst) begin
         model_busy <= 1'b0;
         model_cnt  <= 0;
         tx_done    <= 1'b0;
      end else begin
         tx_done <= 1'b0;
         if (tx_dv) begin
            model_busy <= 1'b1;
            model_cnt  <= 3;
         end else if (model_busy) begin
            if (model_cnt == 0) begin
               model_busy <= 1'b0;
               tx_done    <= 1'b1;
            end else begin
               model_cnt <= model_cnt - 1;
            end
         end
      end
   end

   // Capture transmitted bytes and count output pulses, sampled mid-cycle
   always @(negedge clk) begin
      if (tx_dv) begin
         act_mem[act_wr[7:0]] <= tx_byte;
         act_wr <= act_wr + 1;
      end
      if (frame_error) n_err        <= n_err + 1;
      if (stage_stb)   n_stage_stb  <= n_stage_stb + 1;
      if (status_stb)  n_status_stb <= n_status_stb + 1;
      if (poweron_stb) n_pon_stb    <= n_pon_stb + 1;
   end

   task automatic send_byte(input logic [7:0] b);
      @(posedge clk); #1;
      rx_dv   = 1'b1;
      rx_byte = b;
      @(posedge clk); #1;
      rx_dv   = 1'b0;
      repeat (12) @(posedge clk);
      #1;
   endtask

   task automatic expect_ack();
`ifdef MCU_LINK_ACK_EN
      exp_q.push_back(8'h10);
`endif
   endtask

   task automatic test_reset();
      rst = 1'b1; rx_dv = 1'b0; rx_byte = 8'h00; hold_busy = 1'b0;
      local_set = 1'b0; local_slot = 2'd0; local_pa = 1'b0; local_aa = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      n_cmp++; if (ip !== 32'h0 || ip_valid !== 1'b0) begin n_bad++; $display("FAIL reset_ip: got %h/%b want 0/0", ip, ip_valid); end
      n_cmp++; if (fw_version !== 64'h0 || version_valid !== 1'b0 || fw_type !== 4'h0) begin n_bad++; $display("FAIL reset_ver: got %h/%b/%h want 0", fw_version, version_valid, fw_type); end
      n_cmp++; if (stage !== 4'h0 || slot !== 2'd0 || power_amplifier !== 1'b0 || audio_amplifier !== 1'b0) begin n_bad++; $display("FAIL reset_regs: got stage %h slot %0d pa %b aa %b want 0", stage, slot, power_amplifier, audio_amplifier); end
      n_cmp++; if (poweron !== 1'b0) begin n_bad++; $display("FAIL reset_poweron: got %b want 0", poweron); end
      n_cmp++; if (tx_dv !== 1'b0 || frame_error !== 1'b0 || stage_stb !== 1'b0 || status_stb !== 1'b0 || poweron_stb !== 1'b0) begin n_bad++; $display("FAIL reset_strobes: got a strobe high, want all 0"); end
      rst = 1'b0;
      repeat (2) @(posedge clk);
      #1;
   endtask

   task automatic test_boot();
      logic [7:0] e, a;
      send_byte(8'h40);
      send_byte(8'hC0); send_byte(8'hA8); send_byte(8'h01);
      expect_ack();
      send_byte(8'h0A);
      for (int i = 0; i < 12; i++) send_byte(8'h00);
      send_byte(8'h31);
      for (int i = 1; i <= 7; i++) send_byte(8'(i));
      expect_ack();
      send_byte(8'h08);
      expect_ack();
      send_byte(8'h23);
      exp_q.push_back(8'h50);
      send_byte(8'h50);
      exp_q.push_back(8'h62);
      send_byte(8'h60);
      n_cmp++; if (ip !== 32'hC0A8010A || ip_valid !== 1'b1) begin n_bad++; $display("FAIL boot_ip: got %h/%b want c0a8010a/1", ip, ip_valid); end
      n_cmp++; if (fw_version !== 64'h0102030405060708 || version_valid !== 1'b1) begin n_bad++; $display("FAIL boot_ver: got %h/%b want 0102030405060708/1", fw_version, version_valid); end
      n_cmp++; if (fw_type !== 4'h1) begin n_bad++; $display("FAIL boot_type: got %h want 1", fw_type); end
      n_cmp++; if (stage !== 4'h3 || n_stage_stb != 1) begin n_bad++; $display("FAIL boot_stage: got %h stb %0d want 3 stb 1", stage, n_stage_stb); end
      n_cmp++; if (n_err != 0) begin n_bad++; $display("FAIL boot_noerr: got %0d errors want 0", n_err); end
      repeat (40) @(posedge clk);
      #1;
      while (exp_q.size() != 0) begin
         e = exp_q.pop_front();
         n_cmp++;
         if (act_rd >= act_wr) begin n_bad++; $display("FAIL boot_tx: got none want %h", e); end
         else begin a = act_mem[act_rd[7:0]]; act_rd++; if (a !== e) begin n_bad++; $display("FAIL boot_tx: got %h want %h", a, e); end end
      end
      n_cmp++; if (act_wr != act_rd) begin n_bad++; $display("FAIL boot_tx_extra: got %0d extra want 0", act_wr - act_rd); act_rd = act_wr; end
   endtask

   task automatic test_push();
      logic [7:0] e, a;
      int s0, p0;
      s0 = n_status_stb; p0 = n_pon_stb;
      expect_ack();
      send_byte(8'h5B);
      n_cmp++; if (slot !== 2'd2 || power_amplifier !== 1'b1 || audio_amplifier !== 1'b1) begin n_bad++; $display("FAIL push_status: got slot %0d pa %b aa %b want 2 1 1", slot, power_amplifier, audio_amplifier); end
      n_cmp++; if (n_status_stb != s0 + 1) begin n_bad++; $display("FAIL push_status_stb: got %0d want %0d", n_status_stb, s0 + 1); end
      expect_ack();
      send_byte(8'h61);
      n_cmp++; if (poweron !== 1'b1 || n_pon_stb != p0 + 1) begin n_bad++; $display("FAIL push_poweron: got %b stb %0d want 1 stb %0d", poweron, n_pon_stb, p0 + 1); end
      repeat (40) @(posedge clk);
      #1;
      while (exp_q.size() != 0) begin
         e = exp_q.pop_front();
         n_cmp++;
         if (act_rd >= act_wr) begin n_bad++; $display("FAIL push_tx: got none want %h", e); end
         else begin a = act_mem[act_rd[7:0]]; act_rd++; if (a !== e) begin n_bad++; $display("FAIL push_tx: got %h want %h", a, e); end end
      end
      n_cmp++; if (act_wr != act_rd) begin n_bad++; $display("FAIL push_tx_extra: got %0d extra want 0", act_wr - act_rd); act_rd = act_wr; end
   endtask

   task automatic test_local();
      logic [7:0] e, a;
      int s0;
      s0 = n_status_stb;
      exp_q.push_back(8'h55);
      @(posedge clk); #1;
      local_set = 1'b1; local_slot = 2'd1; local_pa = 1'b0; local_aa = 1'b1;
      @(posedge clk); #1;
      local_set = 1'b0;
      repeat (20) @(posedge clk);
      #1;
      exp_q.push_back(8'h55);
      expect_ack();
      rx_dv = 1'b1; rx_byte = 8'h5B; local_set = 1'b1;
      @(posedge clk); #1;
      rx_dv = 1'b0; local_set = 1'b0;
      repeat (40) @(posedge clk);
      #1;
      n_cmp++; if (slot !== 2'd1 || power_amplifier !== 1'b0 || audio_amplifier !== 1'b1) begin n_bad++; $display("FAIL local_regs: got slot %0d pa %b aa %b want 1 0 1", slot, power_amplifier, audio_amplifier); end
      n_cmp++; if (n_status_stb != s0 + 2) begin n_bad++; $display("FAIL local_stb: got %0d want %0d", n_status_stb, s0 + 2); end
      while (exp_q.size() != 0) begin
         e = exp_q.pop_front();
         n_cmp++;
         if (act_rd >= act_wr) begin n_bad++; $display("FAIL local_tx: got none want %h", e); end
         else begin a = act_mem[act_rd[7:0]]; act_rd++; if (a !== e) begin n_bad++; $display("FAIL local_tx: got %h want %h", a, e); end end
      end
      n_cmp++; if (act_wr != act_rd) begin n_bad++; $display("FAIL local_tx_extra: got %0d extra want 0", act_wr - act_rd); act_rd = act_wr; end
   endtask

   task automatic test_timeout();
      logic [7:0] e, a;
      int e0;
      e0 = n_err;
      send_byte(8'h40);
      send_byte(8'hC0);
      n_cmp++; if (n_err != e0) begin n_bad++; $display("FAIL timeout_early: got %0d errors want %0d", n_err, e0); end
      repeat (TIMEOUT + 20) @(posedge clk);
      #1;
      n_cmp++; if (n_err != e0 + 1) begin n_bad++; $display("FAIL timeout_err: got %0d errors want %0d", n_err, e0 + 1); end
      n_cmp++; if (ip !== 32'hC0A8010A) begin n_bad++; $display("FAIL timeout_ip: got %h want c0a8010a", ip); end
      expect_ack();
      send_byte(8'h24);
      n_cmp++; if (stage !== 4'h4 || n_err != e0 + 1) begin n_bad++; $display("FAIL timeout_resync: got stage %h errors %0d want 4 errors %0d", stage, n_err, e0 + 1); end
      repeat (40) @(posedge clk);
      #1;
      while (exp_q.size() != 0) begin
         e = exp_q.pop_front();
         n_cmp++;
         if (act_rd >= act_wr) begin n_bad++; $display("FAIL timeout_tx: got none want %h", e); end
         else begin a = act_mem[act_rd[7:0]]; act_rd++; if (a !== e) begin n_bad++; $display("FAIL timeout_tx: got %h want %h", a, e); end end
      end
      n_cmp++; if (act_wr != act_rd) begin n_bad++; $display("FAIL timeout_tx_extra: got %0d extra want 0", act_wr - act_rd); act_rd = act_wr; end
   endtask

   task automatic test_errors();
      int e0;
      e0 = n_err;
      send_byte(8'h63);
      n_cmp++; if (n_err != e0 + 1 || poweron !== 1'b1) begin n_bad++; $display("FAIL err_63: got errors %0d poweron %b want %0d 1", n_err, poweron, e0 + 1); end
      send_byte(8'h7F);
      n_cmp++; if (n_err != e0 + 2) begin n_bad++; $display("FAIL err_7f: got %0d want %0d", n_err, e0 + 2); end
      send_byte(8'h40);
      send_byte(8'h0A); send_byte(8'h0B); send_byte(8'h0C); send_byte(8'h0D);
      for (int i = 0; i < 12; i++) send_byte((i == 5) ? 8'h01 : 8'h00);
      n_cmp++; if (n_err != e0 + 3) begin n_bad++; $display("FAIL err_pad: got %0d errors want %0d", n_err, e0 + 3); end
      n_cmp++; if (ip !== 32'hC0A8010A || ip_valid !== 1'b1) begin n_bad++; $display("FAIL err_pad_ip: got %h/%b want c0a8010a/1", ip, ip_valid); end
      repeat (40) @(posedge clk);
      #1;
      n_cmp++; if (act_wr != act_rd) begin n_bad++; $display("FAIL err_tx: got %0d bytes want 0", act_wr - act_rd); act_rd = act_wr; end
   endtask

   task automatic test_back_to_back();
      logic [7:0] e, a;
      hold_busy = 1'b1;
      exp_q.push_back(8'h55);
      send_byte(8'h50);
      exp_q.push_back(8'h61);
      send_byte(8'h60);
      send_byte(8'h50);
      n_cmp++; if (act_wr != act_rd) begin n_bad++; $display("FAIL b2b_busy: got %0d bytes while busy want 0", act_wr - act_rd); end
      hold_busy = 1'b0;
      repeat (40) @(posedge clk);
      #1;
      while (exp_q.size() != 0) begin
         e = exp_q.pop_front();
         n_cmp++;
         if (act_rd >= act_wr) begin n_bad++; $display("FAIL b2b_tx: got none want %h", e); end
         else begin a = act_mem[act_rd[7:0]]; act_rd++; if (a !== e) begin n_bad++; $display("FAIL b2b_tx: got %h want %h", a, e); end end
      end
      n_cmp++; if (act_wr != act_rd) begin n_bad++; $display("FAIL b2b_tx_extra: got %0d extra want 0", act_wr - act_rd); act_rd = act_wr; end
   endtask

   task automatic test_ack();
      logic [7:0] e, a;
      expect_ack();
      send_byte(8'h23);
      n_cmp++; if (stage !== 4'h3) begin n_bad++; $display("FAIL ack_stage: got %h want 3", stage); end
      repeat (40) @(posedge clk);
      #1;
      while (exp_q.size() != 0) begin
         e = exp_q.pop_front();
         n_cmp++;
         if (act_rd >= act_wr) begin n_bad++; $display("FAIL ack_tx: got none want %h", e); end
         else begin a = act_mem[act_rd[7:0]]; act_rd++; if (a !== e) begin n_bad++; $display("FAIL ack_tx: got %h want %h", a, e); end end
      end
      n_cmp++; if (act_wr != act_rd) begin n_bad++; $display("FAIL ack_tx_extra: got %0d extra want 0", act_wr - act_rd); act_rd = act_wr; end
   endtask

   initial begin
      test_reset();
      test_boot();
      test_push();
      test_local();
      test_timeout();
      test_errors();
      test_back_to_back();
      test_ack();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
`default_nettype wire
